// File: rtl/dmem_lsu_port_if.sv
// CPU request/response channel plus SRAM port-2 signals of the data-memory LSU.
interface dmem_lsu_port_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] abus2;
    logic [31:0]       dbus2i;
    logic [31:0]       dbus2o;
    logic              re2;
    logic [3:0]        bwe;

    // slave: the LSU itself; master: the CPU plus SRAM environment around it
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dbus2o,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, abus2, dbus2i, re2, bwe
    );
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dbus2o,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, abus2, dbus2i, re2, bwe
    );
endinterface

// File: rtl/dmem_lsu_port.sv
// Single-outstanding load/store unit for SRAM port 2: lane enables and replication
// for stores, lane extraction and sign/zero extension for loads.
//
//  state  | meaning
//  IDLE   | ready for a request
//  ISSUE  | SRAM samples abus2/bwe/re2 at the end of this cycle
//  WAIT   | read data on dbus2o, extracted into rsp_rdata
//  ERR    | misaligned/illegal request, no SRAM access
//  RESP   | one-cycle rsp_valid pulse
module dmem_lsu_port #(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_lsu_port_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ERR   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        off_q;
    logic [3:0]        bwe_q;
    logic [ADDR_W-1:0] abus2_q;
    logic [31:0]       dbus2i_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              illegal;
    logic [1:0]        off_in;
    logic [3:0]        bwe_enc;
    logic [31:0]       wdata_rep;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_ext;

    assign off_in = bus.req_addr[1:0];
    assign accept = bus.req_valid && (state_q == S_IDLE);

    always_comb begin
        illegal = 1'b0;
        case (bus.req_size)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = off_in[0];
            2'b10:   illegal = (off_in != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        bwe_enc   = 4'b1111;
        wdata_rep = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                bwe_enc   = 4'b0001 << off_in;
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                bwe_enc   = off_in[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                bwe_enc   = 4'b1111;
                wdata_rep = bus.req_wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = bus.dbus2o[{off_q, 3'b000} +: 8];
        ld_half = bus.dbus2o[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_ext = bus.dbus2o;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = illegal ? S_ERR : S_ISSUE;
            S_ISSUE: state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_ERR:   state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == S_IDLE);
        bus.rsp_valid = (state_q == S_RESP);
        bus.re2       = (state_q == S_ISSUE) && !we_q;
        bus.bwe       = ((state_q == S_ISSUE) && we_q) ? bwe_q : 4'b0000;
        bus.abus2     = abus2_q;
        bus.dbus2i    = dbus2i_q;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            off_q    <= 2'b00;
            bwe_q    <= 4'b0000;
            abus2_q  <= '0;
            dbus2i_q <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= bus.req_we;
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
                off_q    <= off_in;
                if (!illegal) begin
                    abus2_q <= bus.req_addr[ADDR_W+1:2];
                    if (bus.req_we) begin
                        bwe_q    <= bwe_enc;
                        dbus2i_q <= wdata_rep;
                    end
                end
            end
            // response payload is staged the cycle before RESP so it is stable with rsp_valid
            case (state_q)
                S_ISSUE: if (we_q) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b0;
                end
                S_WAIT: begin
                    rdata_q <= ld_ext;
                    err_q   <= 1'b0;
                end
                S_ERR: begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_lsu_port.sv
// Bench for dmem_lsu_port: byte-level memory model predicts every cycle's outputs,
// directed transactions also pin latencies and load results to literals.
module tb_dmem_lsu_port;
    localparam int AW    = 10;
    localparam int DEPTH = 2048;
    localparam int NBYTE = 4 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nmis = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_lsu_port_if #(.ADDR_W(AW)) bus ();
    dmem_lsu_port #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] sram [1 << AW];
    always @(posedge clk) begin
        if (bus.re2) bus.dbus2o <= sram[bus.abus2];
        for (int j = 0; j < 4; j++)
            if (bus.bwe[j]) sram[bus.abus2][8*j +: 8] <= bus.dbus2i[8*j +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: schedule of expected per-cycle SRAM and response activity
    logic [7:0]    ref_mem [NBYTE];
    logic          s_rsp   [DEPTH];
    logic [31:0]   s_rdata [DEPTH];
    logic          s_err   [DEPTH];
    logic [3:0]    s_bwe   [DEPTH];
    logic          s_re2   [DEPTH];
    logic [AW-1:0] s_addr  [DEPTH];
    logic [31:0]   s_wdata [DEPTH];
    int            busy_until = -1;
    logic [31:0]   h_rdata = 0;
    logic          h_err = 0;
    logic [AW-1:0] h_abus = 0;
    int            bwe_cnt = 0;
    int            dbl_rsp = 0;
    logic          prev_rsp = 0;

    always @(negedge clk) begin
        logic rdy_e;
        int nb, off, base;
        logic bad;
        logic [3:0] mask;
        logic [31:0] data, v;
        rdy_e = 1'b1;
        if (!rst_n) begin
            for (int i = cyc; i < DEPTH; i++) begin
                s_rsp[i] = 0; s_bwe[i] = 0; s_re2[i] = 0;
            end
            busy_until = -1; h_rdata = 0; h_err = 0; h_abus = 0;
        end else begin
            rdy_e = (cyc > busy_until);
            if (bus.req_valid && rdy_e && cyc + 3 < DEPTH) begin
                nb   = 1 << bus.req_size;
                base = int'(bus.req_addr);
                off  = base % 4;
                bad  = (bus.req_size == 2'b11) || (base % nb != 0);
                if (bad) begin
                    s_rsp[cyc+2] = 1; s_rdata[cyc+2] = 0; s_err[cyc+2] = 1;
                    busy_until = cyc + 2;
                end else if (bus.req_we) begin
                    mask = 0; data = 0;
                    for (int j = 0; j < 4; j++) begin
                        if (j >= off && j < off + nb) mask[j] = 1'b1;
                        data[8*j +: 8] = 8'(bus.req_wdata >> (8 * (j % nb)));
                    end
                    s_bwe[cyc+1] = mask; s_addr[cyc+1] = AW'(base / 4); s_wdata[cyc+1] = data;
                    s_rsp[cyc+2] = 1; s_rdata[cyc+2] = 0; s_err[cyc+2] = 0;
                    busy_until = cyc + 2;
                end else begin
                    v = 0;
                    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[base + i];
                    if (bus.req_signed && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                    s_re2[cyc+1] = 1; s_addr[cyc+1] = AW'(base / 4);
                    s_rsp[cyc+3] = 1; s_rdata[cyc+3] = v; s_err[cyc+3] = 0;
                    busy_until = cyc + 3;
                end
            end
            if (s_bwe[cyc] != 0)
                for (int j = 0; j < 4; j++)
                    if (s_bwe[cyc][j]) ref_mem[int'(s_addr[cyc]) * 4 + j] = s_wdata[cyc][8*j +: 8];
            if (s_bwe[cyc] != 0 || s_re2[cyc]) h_abus = s_addr[cyc];
            if (s_rsp[cyc]) begin
                h_rdata = s_rdata[cyc]; h_err = s_err[cyc];
            end
        end
        chk("req_ready", 32'(bus.req_ready), 32'(rdy_e));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(s_rsp[cyc] && rst_n));
        chk("bwe", 32'(bus.bwe), 32'(rst_n ? s_bwe[cyc] : 4'b0));
        chk("re2", 32'(bus.re2), 32'(s_re2[cyc] && rst_n));
        chk("abus2", 32'(bus.abus2), 32'(h_abus));
        if (rst_n && s_bwe[cyc] != 0) chk("dbus2i", bus.dbus2i, s_wdata[cyc]);
        chk("rsp_rdata", bus.rsp_rdata, h_rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(h_err));
        if (bus.bwe != 4'b0) bwe_cnt++;
        if (bus.rsp_valid && prev_rsp) dbl_rsp++;
        prev_rsp = bus.rsp_valid;
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [AW+1:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        logic got;
        bus.req_valid = 1; bus.req_we = we; bus.req_size = size;
        bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 0;
        n = 0; got = 0;
        while (n < 10 && !got) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid) got = 1;
        end
        chk("lit_latency", 32'(n), 32'(exp_lat));
        chk("lit_rdata", bus.rsp_rdata, exp_rdata);
        chk("lit_err", 32'(bus.rsp_err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [9:0] rdy_pat;
        int bwe0;
        for (int i = 0; i < (1 << AW); i++) sram[i] = 32'h0;
        for (int i = 0; i < NBYTE; i++) ref_mem[i] = 8'h0;
        for (int i = 0; i < DEPTH; i++) begin
            s_rsp[i] = 0; s_bwe[i] = 0; s_re2[i] = 0; s_rdata[i] = 0;
            s_err[i] = 0; s_addr[i] = 0; s_wdata[i] = 0;
        end
        bus.dbus2o = 0; bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0;
        bus.req_signed = 0; bus.req_addr = 0; bus.req_wdata = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        do_req(1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 2, 32'h0, 0);
        do_req(1, 2'b00, 0, 12'h013, 32'h000000A5, 2, 32'h0, 0);
        do_req(0, 2'b10, 0, 12'h010, 32'h0, 3, 32'hA5ADBEEF, 0);
        do_req(0, 2'b00, 1, 12'h013, 32'h0, 3, 32'hFFFFFFA5, 0);
        do_req(0, 2'b00, 0, 12'h013, 32'h0, 3, 32'h000000A5, 0);
        do_req(0, 2'b01, 1, 12'h012, 32'h0, 3, 32'hFFFFA5AD, 0);
        do_req(0, 2'b01, 0, 12'h010, 32'h0, 3, 32'h0000BEEF, 0);
        do_req(0, 2'b01, 1, 12'h010, 32'h0, 3, 32'hFFFFBEEF, 0);
        do_req(0, 2'b00, 1, 12'h011, 32'h0, 3, 32'h00000000 | 32'hFFFFFFBE, 0);
        do_req(0, 2'b01, 0, 12'h011, 32'h0, 2, 32'h0, 1);
        do_req(0, 2'b11, 0, 12'h010, 32'h0, 2, 32'h0, 1);
        do_req(1, 2'b10, 0, 12'h022, 32'h12345678, 2, 32'h0, 1);
        do_req(1, 2'b01, 0, 12'h022, 32'h00001234, 2, 32'h0, 0);
        do_req(0, 2'b10, 0, 12'h020, 32'h0, 3, 32'h12340000, 0);
        do_req(0, 2'b01, 1, 12'h022, 32'h0, 3, 32'h00001234, 0);

        // held req_valid: one accept every third cycle
        bwe0 = bwe_cnt;
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'b10;
        bus.req_signed = 0; bus.req_addr = 12'h040;
        for (int i = 0; i < 10; i++) begin
            bus.req_wdata = 32'h1000 + i;
            @(negedge clk);
            rdy_pat[i] = bus.req_ready;
            @(posedge clk); #1;
        end
        bus.req_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("lit_ready_pattern", 32'(rdy_pat), 32'(10'b1001001001));
        chk("lit_bwe_pulses", 32'(bwe_cnt - bwe0), 32'd4);
        chk("lit_double_rsp", 32'(dbl_rsp), 32'd0);

        // reset in the middle of a store's ISSUE cycle
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'b10;
        bus.req_addr = 12'h010; bus.req_wdata = 32'h11223344;
        @(posedge clk); #1;
        bus.req_valid = 0;
        #1 rst_n = 0;
        #1 chk("lit_bwe_in_reset", 32'(bus.bwe), 32'd0);
        chk("lit_ready_in_reset", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        do_req(0, 2'b10, 0, 12'h010, 32'h0, 3, 32'hA5ADBEEF, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
